// File: rtl/addr_seq_pkg.sv
// Shared constants and types for the address sequencer.
package addr_seq_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_INC  = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

  // Width of the source index; never narrower than one bit.
  function automatic int sel_width(input int nsrc);
    return (nsrc <= 2) ? 1 : $clog2(nsrc);
  endfunction

  // Per-stage flags. The address field is AW wide and is prepended by the
  // user, so a stage payload is {address, stage_tag_t}.
  typedef struct packed {
    logic vld;
    logic wrap;
  } stage_tag_t;

  function automatic int payload_width(input int aw);
    return aw + $bits(stage_tag_t);
  endfunction

endpackage

// File: rtl/addr_delay_line.sv
// Fixed-depth register delay line with a shared advance enable and async clear.
module addr_delay_line #(
  parameter int W     = 6,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_reg [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     stage_reg[gi] <= '0;
        else if (en) stage_reg[gi] <= din;
      end
    end else begin : g_rest
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     stage_reg[gi] <= '0;
        else if (en) stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/addr_sequencer.sv
// Address sequencer: LOAD/INC/HOLD front end followed by a DELAY-deep pipeline.
// Optional ADDR_BOUND_EN build: INC wraps to lim_lo when the sum exceeds lim_hi.
module addr_sequencer
  import addr_seq_pkg::*;
#(
  parameter  int AW    = 4,
  parameter  int NSRC  = 2,
  parameter  int DELAY = 2,
  localparam int SW    = sel_width(NSRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC*AW-1:0] src,
  input  logic [SW-1:0]    sel,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    stride,
  input  logic             en,
`ifdef ADDR_BOUND_EN
  input  logic [AW-1:0]    lim_lo,
  input  logic [AW-1:0]    lim_hi,
`endif
  output logic [AW-1:0]    cur,
  output logic [AW-1:0]    addr,
  output logic             addr_vld,
  output logic             addr_wrap
);

  localparam int PW = payload_width(AW);

  logic [AW-1:0] cur_reg, cur_next;
  stage_tag_t    tag0_reg, tag0_next;
  logic [AW-1:0] src_sel;
  logic [AW:0]   sum;
  logic [PW-1:0] line_out;

  // Out-of-range indices fall back to source 0.
  always_comb begin
    src_sel = src[AW-1:0];
    if (int'(sel) < NSRC) src_sel = src[int'(sel)*AW +: AW];
  end

  assign sum = {1'b0, cur_reg} + {1'b0, stride};

  always_comb begin
    cur_next       = cur_reg;
    tag0_next.vld  = 1'b0;
    tag0_next.wrap = 1'b0;
    case (mode)
      MODE_LOAD: begin
        cur_next      = src_sel;
        tag0_next.vld = 1'b1;
      end
      MODE_INC: begin
        tag0_next.vld = 1'b1;
`ifdef ADDR_BOUND_EN
        if (sum > {1'b0, lim_hi}) begin
          cur_next       = lim_lo;
          tag0_next.wrap = 1'b1;
        end else begin
          cur_next = sum[AW-1:0];
        end
`else
        cur_next       = sum[AW-1:0];
        tag0_next.wrap = sum[AW];
`endif
      end
      default: ;  // HOLD and the reserved code keep cur
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_reg  <= '0;
      tag0_reg <= '0;
    end else if (en) begin
      cur_reg  <= cur_next;
      tag0_reg <= tag0_next;
    end
  end

  addr_delay_line #(
    .W     (PW),
    .DEPTH (DELAY)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  ({cur_reg, tag0_reg}),
    .dout (line_out)
  );

  assign cur       = cur_reg;
  assign addr      = line_out[PW-1 -: AW];
  assign addr_vld  = line_out[1];
  assign addr_wrap = line_out[0];

`ifdef ADDR_BOUND_EN
  a_lim_order: assert property (@(posedge clk) disable iff (rst) lim_lo <= lim_hi)
    else $error("lim_lo above lim_hi");
`endif

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed self-checking bench for addr_sequencer (AW=4, NSRC=2, DELAY=2).
module tb_addr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic [0:0] sel;
  logic [1:0] mode;
  logic [3:0] stride;
  logic       en;
`ifdef ADDR_BOUND_EN
  logic [3:0] lim_lo;
  logic [3:0] lim_hi;
`endif
  logic [3:0] cur;
  logic [3:0] addr;
  logic       addr_vld;
  logic       addr_wrap;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  addr_sequencer #(.AW(4), .NSRC(2), .DELAY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .sel       (sel),
    .mode      (mode),
    .stride    (stride),
    .en        (en),
`ifdef ADDR_BOUND_EN
    .lim_lo    (lim_lo),
    .lim_hi    (lim_hi),
`endif
    .cur       (cur),
    .addr      (addr),
    .addr_vld  (addr_vld),
    .addr_wrap (addr_wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b00; src = '0; sel = '0; stride = '0;
`ifdef ADDR_BOUND_EN
    lim_lo = 4'h0; lim_hi = 4'hF;
`endif
    tick();
    tick();
    vectors++;
    if ({cur, addr, addr_vld, addr_wrap} !== 10'b0) begin
      $display("FAIL reset_state got cur=%h addr=%h vld=%b wrap=%b want all 0", cur, addr, addr_vld, addr_wrap);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    $display("reset released: cur=%h addr=%h vld=%b", cur, addr, addr_vld);
  endtask

  task automatic test_load_latency();
    src = {4'h0, 4'h3}; sel = 1'b0; mode = 2'b01;
    tick();
    vectors++;
    if (cur !== 4'h3) begin
      $display("FAIL load_cur got %h want 3", cur); miscompares++;
    end
    mode = 2'b00;
    tick();
    vectors++;
    if (addr_vld !== 1'b0) begin
      $display("FAIL load_early_vld got %b want 0", addr_vld); miscompares++;
    end
    tick();
    vectors++;
    if (addr !== 4'h3 || addr_vld !== 1'b1 || addr_wrap !== 1'b0) begin
      $display("FAIL load_out got addr=%h vld=%b wrap=%b want 3/1/0", addr, addr_vld, addr_wrap);
      miscompares++;
    end
    tick();
    vectors++;
    if (addr_vld !== 1'b0) begin
      $display("FAIL load_vld_drop got %b want 0", addr_vld); miscompares++;
    end
    $display("load latency: addr=%h vld=%b", addr, addr_vld);
  endtask

  task automatic test_alternating();
    logic [3:0] exp_a;
    src = {4'hA, 4'h5};
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        mode = 2'b01; sel = 1'(j % 2);
      end else begin
        mode = 2'b00;
      end
      tick();
      if (j >= 2) begin
        exp_a = ((j - 2) % 2 == 1) ? 4'hA : 4'h5;
        vectors++;
        if (addr !== exp_a || addr_vld !== 1'b1) begin
          $display("FAIL alt_%0d got addr=%h vld=%b want %h/1", j, addr, addr_vld, exp_a);
          miscompares++;
        end
        $display("alternating: edge %0d addr=%h vld=%b", j, addr, addr_vld);
      end
    end
    mode = 2'b00;
    tick();
    tick();
  endtask

`ifndef ADDR_BOUND_EN
  task automatic test_modulo_inc();
    src = {4'h0, 4'hE}; sel = 1'b0; mode = 2'b01;
    tick();
    mode = 2'b10; stride = 4'h3;
    tick();
    vectors++;
    if (cur !== 4'h1) begin
      $display("FAIL inc_cur got %h want 1", cur); miscompares++;
    end
    mode = 2'b00;
    tick();
    vectors++;
    if (addr !== 4'hE || addr_vld !== 1'b1 || addr_wrap !== 1'b0) begin
      $display("FAIL inc_prev got addr=%h vld=%b wrap=%b want E/1/0", addr, addr_vld, addr_wrap);
      miscompares++;
    end
    tick();
    vectors++;
    if (addr !== 4'h1 || addr_vld !== 1'b1 || addr_wrap !== 1'b1) begin
      $display("FAIL inc_wrap got addr=%h vld=%b wrap=%b want 1/1/1", addr, addr_vld, addr_wrap);
      miscompares++;
    end
    // A non-carrying step must not flag wrap.
    mode = 2'b10; stride = 4'h2;
    tick();
    mode = 2'b00;
    tick();
    tick();
    vectors++;
    if (addr !== 4'h3 || addr_wrap !== 1'b0) begin
      $display("FAIL inc_nowrap got addr=%h wrap=%b want 3/0", addr, addr_wrap);
      miscompares++;
    end
    $display("modulo inc: addr=%h wrap=%b", addr, addr_wrap);
  endtask
`else
  task automatic test_bounded_inc();
    lim_lo = 4'h2; lim_hi = 4'h9;
    src = {4'h0, 4'h7}; sel = 1'b0; mode = 2'b01;
    tick();
    mode = 2'b10; stride = 4'h2;
    tick();
    vectors++;
    if (cur !== 4'h9) begin
      $display("FAIL bound_cur9 got %h want 9", cur); miscompares++;
    end
    tick();
    vectors++;
    if (cur !== 4'h2) begin
      $display("FAIL bound_cur2 got %h want 2", cur); miscompares++;
    end
    mode = 2'b00;
    tick();
    vectors++;
    if (addr !== 4'h9 || addr_wrap !== 1'b0) begin
      $display("FAIL bound_out9 got addr=%h wrap=%b want 9/0", addr, addr_wrap); miscompares++;
    end
    tick();
    vectors++;
    if (addr !== 4'h2 || addr_wrap !== 1'b1) begin
      $display("FAIL bound_out2 got addr=%h wrap=%b want 2/1", addr, addr_wrap); miscompares++;
    end
    tick();
    lim_lo = 4'h0; lim_hi = 4'hF;
    $display("bounded inc: addr=%h wrap=%b", addr, addr_wrap);
  endtask
`endif

  task automatic test_stall();
    logic [3:0] seq [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic [3:0] got [$];
    logic [3:0] snap_cur, snap_addr;
    logic       snap_vld, snap_wrap;
    int         n = 0;
    mode = 2'b01; sel = 1'b0;
    for (int j = 0; j < 9; j++) begin
      en = !(j >= 2 && j < 5);
      if (en) begin
        mode = (n < 4) ? 2'b01 : 2'b00;
        if (n < 4) src = {4'h0, seq[n]};
        n++;
      end else begin
        // Drive a different op during the stall; it must be ignored.
        mode = 2'b01; src = {4'h0, 4'hF};
      end
      if (j == 2) begin
        snap_cur = cur; snap_addr = addr; snap_vld = addr_vld; snap_wrap = addr_wrap;
      end
      tick();
      if (!en) begin
        vectors++;
        if (cur !== snap_cur || addr !== snap_addr || addr_vld !== snap_vld || addr_wrap !== snap_wrap) begin
          $display("FAIL stall_freeze_%0d got cur=%h addr=%h vld=%b want cur=%h addr=%h vld=%b",
                   j, cur, addr, addr_vld, snap_cur, snap_addr, snap_vld);
          miscompares++;
        end
      end else if (addr_vld) begin
        got.push_back(addr);
      end
      $display("stall: edge %0d en=%b cur=%h addr=%h vld=%b", j, en, cur, addr, addr_vld);
    end
    en = 1'b1; mode = 2'b00;
    vectors++;
    if (got.size() != 4) begin
      $display("FAIL stall_count got %0d want 4", got.size()); miscompares++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (got[i] !== seq[i]) begin
          $display("FAIL stall_seq_%0d got %h want %h", i, got[i], seq[i]); miscompares++;
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    en = 1'b1; sel = 1'b0; mode = 2'b01;
    src = {4'h0, 4'h7};
    tick();
    src = {4'h0, 4'h8};
    tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({cur, addr, addr_vld, addr_wrap} !== 10'b0) begin
      $display("FAIL midreset_async got cur=%h addr=%h vld=%b wrap=%b want all 0", cur, addr, addr_vld, addr_wrap);
      miscompares++;
    end
    mode = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      vectors++;
      if (addr_vld !== 1'b0 || addr !== 4'h0 || cur !== 4'h0) begin
        $display("FAIL midreset_flush_%0d got cur=%h addr=%h vld=%b want 0/0/0", j, cur, addr, addr_vld);
        miscompares++;
      end
    end
    $display("midstream reset: cur=%h addr=%h vld=%b", cur, addr, addr_vld);
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_alternating();
`ifndef ADDR_BOUND_EN
    test_modulo_inc();
`else
    test_bounded_inc();
`endif
    test_stall();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
